rs_age_station: RTL and testbench
=================================

# rs_age_station

Parametrised reservation station for the out-of-order core, sitting between the Decoder and the ALU. It buffers up to `RS_DEPTH` issued ALU instructions and snoops `NUM_CDB` result broadcast channels (ALU result, LSB load result, and any further units) to resolve operand dependencies, including broadcasts that arrive in the same cycle as issue. It dispatches the oldest fully-ready entry into a registered valid/ready execute port, holding it under ALU back-pressure. Unlike the previous station, selection is strictly oldest-first via an age matrix, and occupancy is exported as a count.

## Interface
- `RS_DEPTH`, 8: number of entries, power of two, 2..32
- `ROB_W`, 4: RoB tag width
- `NUM_CDB`, 2: number of broadcast channels, 1..4
- `XLEN`, 32: operand width

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `rdy`  in  1  global enable; low freezes all state
- `flush`  in  1  RoB mispredict clear; drops all entries
- `issue_valid`  in  1  Decoder presents an instruction
- `issue_op`  in  3  funct3
- `issue_type`  in  7  opcode
- `issue_alt`  in  1  instr bit 30 (SUB/SRA select)
- `issue_v1`, `issue_v2`  in  XLEN  operand values (valid when dep bit low)
- `issue_dep1`, `issue_dep2`  in  1  operand waits on a tag
- `issue_tag1`, `issue_tag2`  in  ROB_W  producer tags
- `issue_rd_tag`  in  ROB_W  destination RoB tag
- `cdb_valid`  in  NUM_CDB  per-channel broadcast valid
- `cdb_tag`  in  NUM_CDB*ROB_W  packed tags, channel 0 in LSBs
- `cdb_value`  in  NUM_CDB*XLEN  packed values
- `rs_full`  out  1  count == RS_DEPTH
- `rs_free_cnt`  out  $clog2(RS_DEPTH+1)  free entries
- `ex_valid`  out  1  execute port holds an instruction
- `ex_ready`  in  1  ALU accepts this cycle
- `ex_op`, `ex_type`, `ex_alt`, `ex_v1`, `ex_v2`, `ex_rd_tag`  out  as issue fields  registered dispatch payload

## Operation
- Entry state: busy, payload, per-operand {dep, tag, value}; age matrix `older[i][j]` (i older than j).
- Issue: when `issue_valid && !rs_full`, write the lowest-index free entry. For each operand with dep set, if any `cdb_valid[c]` with `cdb_tag[c]` == the operand tag this cycle, store that value and clear dep (same-cycle bypass). On allocation of entry k: `older[j][k]`=1 for every busy j, `older[k][*]`=0.
- `issue_valid` while `rs_full` is ignored (no write, no count change), even if a dispatch frees an entry that same edge.
- Wakeup: every busy entry with dep set and a matching valid channel captures the value and clears dep. Multiple matching channels: lowest channel index wins.
- Select: candidate = busy && !dep1 && !dep2 (registered state). Winner = candidate i with no candidate j where `older[j][i]`.
- Dispatch: when a winner exists and (`!ex_valid || ex_ready`), load the ex_* registers, set `ex_valid`, clear busy of the winner. When `ex_valid && ex_ready` and no winner, clear `ex_valid`. When `ex_valid && !ex_ready`, hold ex_* unchanged.
- Count: free count += dispatch frees, -= accepted issues; both in one cycle leave it unchanged.
- Priority per edge: `!rst_n` > `flush` > `!rdy` > normal operation.

## Timing
- Reset (`rst_n` low at edge): all busy=0, age matrix=0, `ex_valid`=0, ex_* payload=0, `rs_full`=0, `rs_free_cnt`=RS_DEPTH.
- Flush: same as reset for busy, age and `ex_valid`; payload may keep stale data. Issue or broadcast in the flush cycle is dropped.
- `rdy` low: no state change; outputs hold, including `ex_valid` under `ex_ready`.
- Latency: issue with both operands ready at edge N -> `ex_valid` at edge N+1 (if port free). Broadcast at edge N clearing the last dep -> `ex_valid` at edge N+1. Issue with same-cycle bypass at edge N -> `ex_valid` at N+1.
- Throughput: one dispatch per cycle with `ex_ready` held high.
- `rs_full`/`rs_free_cnt` are combinational from registered state, so they are stable throughout the cycle.

## Test plan
- Reset then issue 3 independent ADDs (v1=1..3, v2=10) with `ex_ready`=1 -> `ex_valid` on 3 consecutive cycles, `ex_v1` order 1,2,3, rd tags in issue order, free count returns to 8.
- Fill 8 entries all dep1 on tag 5 -> `rs_full`=1; a 9th issue is ignored; broadcast tag 5 value 0xDEAD on channel 1 -> all 8 dispatch oldest-first with `ex_v1`=0xDEAD.
- Issue entry with dep2 tag 3 while channel 0 broadcasts tag 3 value 42 in the same cycle -> dispatched next edge with `ex_v2`=42.
- Hold `ex_ready`=0 with 2 ready entries -> ex payload stable, `ex_valid`=1, free count 7; release -> second entry follows on next cycle.
- Issue younger ready entry after older one waiting on tag 7; broadcast tag 7 -> younger dispatches first, older next cycle; assert ordering then reversed age if both ready.
- Flush with 4 busy and `ex_valid`=1 -> next cycle `ex_valid`=0, free count 8; `rdy`=0 for 3 cycles mid-stream -> no state change, resumes exactly.

Source files
------------

// File: rtl/rs_age_station.sv
// ALU reservation station: snoops result broadcasts to resolve operands and dispatches
// the oldest ready entry (age-matrix select) into a registered valid/ready execute port.
module rs_age_station #(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned ROB_W    = 4,
  parameter int unsigned NUM_CDB  = 2,
  parameter int unsigned XLEN     = 32,
  localparam int unsigned CNT_W   = $clog2(RS_DEPTH + 1),
  localparam int unsigned IDX_W   = $clog2(RS_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic [2:0]               issue_op,
  input  logic [6:0]               issue_type,
  input  logic                     issue_alt,
  input  logic [XLEN-1:0]          issue_v1,
  input  logic [XLEN-1:0]          issue_v2,
  input  logic                     issue_dep1,
  input  logic                     issue_dep2,
  input  logic [ROB_W-1:0]         issue_tag1,
  input  logic [ROB_W-1:0]         issue_tag2,
  input  logic [ROB_W-1:0]         issue_rd_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  output logic                     rs_full,
  output logic [CNT_W-1:0]         rs_free_cnt,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [2:0]               ex_op,
  output logic [6:0]               ex_type,
  output logic                     ex_alt,
  output logic [XLEN-1:0]          ex_v1,
  output logic [XLEN-1:0]          ex_v2,
  output logic [ROB_W-1:0]         ex_rd_tag
);

  logic [RS_DEPTH-1:0] r_busy, r_dep1, r_dep2;
  logic [2:0]          r_op     [RS_DEPTH];
  logic [6:0]          r_type   [RS_DEPTH];
  logic                r_alt    [RS_DEPTH];
  logic [XLEN-1:0]     r_v1     [RS_DEPTH];
  logic [XLEN-1:0]     r_v2     [RS_DEPTH];
  logic [ROB_W-1:0]    r_tag1   [RS_DEPTH];
  logic [ROB_W-1:0]    r_tag2   [RS_DEPTH];
  logic [ROB_W-1:0]    r_rd_tag [RS_DEPTH];
  logic [RS_DEPTH-1:0] r_older  [RS_DEPTH];

  logic             r_ex_valid;
  logic [2:0]       r_ex_op;
  logic [6:0]       r_ex_type;
  logic             r_ex_alt;
  logic [XLEN-1:0]  r_ex_v1, r_ex_v2;
  logic [ROB_W-1:0] r_ex_rd_tag;

  logic [CNT_W-1:0]    w_free_cnt;
  logic [IDX_W-1:0]    w_alloc_idx;
  logic                w_issue_acc;
  logic [RS_DEPTH-1:0] w_cand, w_win;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_disp;
  logic [RS_DEPTH-1:0] w_hit1, w_hit2;
  logic [XLEN-1:0]     w_wval1 [RS_DEPTH];
  logic [XLEN-1:0]     w_wval2 [RS_DEPTH];
  logic [XLEN:0]       w_iss1, w_iss2;

  // Returns {hit, value}; the lowest matching channel wins.
  function automatic logic [XLEN:0] cdb_match(
    input logic [ROB_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*ROB_W-1:0] tags,
    input logic [NUM_CDB*XLEN-1:0]  vals
  );
    logic [XLEN:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (vld[c] && tags[c*ROB_W +: ROB_W] == tag) res = {1'b1, vals[c*XLEN +: XLEN]};
    end
    return res;
  endfunction

  always_comb begin
    w_free_cnt  = '0;
    w_alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      w_free_cnt = w_free_cnt + CNT_W'(!r_busy[i]);
      if (!r_busy[i]) w_alloc_idx = IDX_W'(i);
    end
  end

  assign rs_full     = (w_free_cnt == '0);
  assign rs_free_cnt = w_free_cnt;
  assign w_issue_acc = issue_valid && !rs_full;
  assign w_cand      = r_busy & ~r_dep1 & ~r_dep2;

  always_comb begin
    w_win     = '0;
    w_win_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_win[i] = w_cand[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (w_cand[j] && r_older[j][i]) w_win[i] = 1'b0;
      end
      if (w_win[i]) w_win_idx = IDX_W'(i);
    end
  end

  assign w_disp = (|w_win) && (!r_ex_valid || ex_ready);

  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      {w_hit1[i], w_wval1[i]} = cdb_match(r_tag1[i], cdb_valid, cdb_tag, cdb_value);
      {w_hit2[i], w_wval2[i]} = cdb_match(r_tag2[i], cdb_valid, cdb_tag, cdb_value);
    end
    w_iss1 = cdb_match(issue_tag1, cdb_valid, cdb_tag, cdb_value);
    w_iss2 = cdb_match(issue_tag2, cdb_valid, cdb_tag, cdb_value);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_dep1      <= '0;
      r_dep2      <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_op     <= '0;
      r_ex_type   <= '0;
      r_ex_alt    <= 1'b0;
      r_ex_v1     <= '0;
      r_ex_v2     <= '0;
      r_ex_rd_tag <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_older[i]  <= '0;
        r_op[i]     <= '0;
        r_type[i]   <= '0;
        r_alt[i]    <= 1'b0;
        r_v1[i]     <= '0;
        r_v2[i]     <= '0;
        r_tag1[i]   <= '0;
        r_tag2[i]   <= '0;
        r_rd_tag[i] <= '0;
      end
    end else if (flush) begin
      r_busy     <= '0;
      r_ex_valid <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) r_older[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (r_busy[i] && r_dep1[i] && w_hit1[i]) begin
          r_dep1[i] <= 1'b0;
          r_v1[i]   <= w_wval1[i];
        end
        if (r_busy[i] && r_dep2[i] && w_hit2[i]) begin
          r_dep2[i] <= 1'b0;
          r_v2[i]   <= w_wval2[i];
        end
      end

      if (w_disp) begin
        r_ex_valid          <= 1'b1;
        r_ex_op             <= r_op[w_win_idx];
        r_ex_type           <= r_type[w_win_idx];
        r_ex_alt            <= r_alt[w_win_idx];
        r_ex_v1             <= r_v1[w_win_idx];
        r_ex_v2             <= r_v2[w_win_idx];
        r_ex_rd_tag         <= r_rd_tag[w_win_idx];
        r_busy[w_win_idx]   <= 1'b0;
      end else if (r_ex_valid && ex_ready) begin
        r_ex_valid <= 1'b0;
      end

      // New entry is younger than everything currently busy.
      if (w_issue_acc) begin
        r_busy[w_alloc_idx]   <= 1'b1;
        r_op[w_alloc_idx]     <= issue_op;
        r_type[w_alloc_idx]   <= issue_type;
        r_alt[w_alloc_idx]    <= issue_alt;
        r_tag1[w_alloc_idx]   <= issue_tag1;
        r_tag2[w_alloc_idx]   <= issue_tag2;
        r_rd_tag[w_alloc_idx] <= issue_rd_tag;
        r_dep1[w_alloc_idx]   <= issue_dep1 && !w_iss1[XLEN];
        r_dep2[w_alloc_idx]   <= issue_dep2 && !w_iss2[XLEN];
        r_v1[w_alloc_idx]     <= (issue_dep1 && w_iss1[XLEN]) ? w_iss1[XLEN-1:0] : issue_v1;
        r_v2[w_alloc_idx]     <= (issue_dep2 && w_iss2[XLEN]) ? w_iss2[XLEN-1:0] : issue_v2;
        for (int j = 0; j < RS_DEPTH; j++) r_older[j][w_alloc_idx] <= r_busy[j];
        r_older[w_alloc_idx] <= '0;
      end
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_op     = r_ex_op;
  assign ex_type   = r_ex_type;
  assign ex_alt    = r_ex_alt;
  assign ex_v1     = r_ex_v1;
  assign ex_v2     = r_ex_v2;
  assign ex_rd_tag = r_ex_rd_tag;

endmodule

// File: tb/tb_rs_age_station.sv
// Bench for rs_age_station: an age-ordered queue model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rs_age_station;
  localparam int unsigned D  = 8;
  localparam int unsigned RW = 4;
  localparam int unsigned NC = 2;
  localparam int unsigned XL = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rdy, flush, issue_valid, issue_alt, issue_dep1, issue_dep2, ex_ready;
  logic [2:0]       issue_op;
  logic [6:0]       issue_type;
  logic [XL-1:0]    issue_v1, issue_v2;
  logic [RW-1:0]    issue_tag1, issue_tag2, issue_rd_tag;
  logic [NC-1:0]    cdb_valid;
  logic [NC*RW-1:0] cdb_tag;
  logic [NC*XL-1:0] cdb_value;
  logic             rs_full, ex_valid, ex_alt;
  logic [3:0]       rs_free_cnt;
  logic [2:0]       ex_op;
  logic [6:0]       ex_type;
  logic [XL-1:0]    ex_v1, ex_v2;
  logic [RW-1:0]    ex_rd_tag;

  rs_age_station #(.RS_DEPTH(D), .ROB_W(RW), .NUM_CDB(NC), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_type(issue_type),
    .issue_alt(issue_alt), .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_dep1(issue_dep1), .issue_dep2(issue_dep2), .issue_tag1(issue_tag1),
    .issue_tag2(issue_tag2), .issue_rd_tag(issue_rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rs_full(rs_full), .rs_free_cnt(rs_free_cnt),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_type(ex_type),
    .ex_alt(ex_alt), .ex_v1(ex_v1), .ex_v2(ex_v2), .ex_rd_tag(ex_rd_tag)
  );

  typedef struct packed {
    logic [2:0]    op;
    logic [6:0]    typ;
    logic          alt;
    logic          dep1;
    logic [RW-1:0] tag1;
    logic [XL-1:0] v1;
    logic          dep2;
    logic [RW-1:0] tag2;
    logic [XL-1:0] v2;
    logic [RW-1:0] rd;
  } ent_t;

  ent_t m_q[$];   // index 0 is the oldest entry
  ent_t m_ex;
  logic m_exv;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit lookup(input logic [RW-1:0] t, output logic [XL-1:0] v);
    v = '0;
    for (int c = 0; c < NC; c++) begin
      if (cdb_valid[c] && cdb_tag[c*RW +: RW] == t) begin
        v = cdb_value[c*XL +: XL];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    int w;
    bit acc;
    ent_t e;
    logic [XL-1:0] v;
    if (!rst_n) begin
      m_q.delete();
      m_exv = 1'b0;
      m_ex  = '0;
    end else if (flush) begin
      m_q.delete();
      m_exv = 1'b0;
    end else if (rdy) begin
      acc = issue_valid && (m_q.size() < D);
      w = -1;
      for (int i = 0; i < m_q.size(); i++) begin
        if (!m_q[i].dep1 && !m_q[i].dep2) begin
          w = i;
          break;
        end
      end
      if (w >= 0 && (!m_exv || ex_ready)) begin
        m_ex  = m_q[w];
        m_exv = 1'b1;
        m_q.delete(w);
      end else if (m_exv && ex_ready) begin
        m_exv = 1'b0;
      end
      for (int i = 0; i < m_q.size(); i++) begin
        if (m_q[i].dep1 && lookup(m_q[i].tag1, v)) begin m_q[i].dep1 = 1'b0; m_q[i].v1 = v; end
        if (m_q[i].dep2 && lookup(m_q[i].tag2, v)) begin m_q[i].dep2 = 1'b0; m_q[i].v2 = v; end
      end
      if (acc) begin
        e = '{op: issue_op, typ: issue_type, alt: issue_alt, dep1: issue_dep1,
              tag1: issue_tag1, v1: issue_v1, dep2: issue_dep2, tag2: issue_tag2,
              v2: issue_v2, rd: issue_rd_tag};
        if (e.dep1 && lookup(e.tag1, v)) begin e.dep1 = 1'b0; e.v1 = v; end
        if (e.dep2 && lookup(e.tag2, v)) begin e.dep2 = 1'b0; e.v2 = v; end
        m_q.push_back(e);
      end
    end
  endtask

  // Outputs compared against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ex_valid", 64'(ex_valid), 64'(m_exv));
        chk("free_cnt", 64'(rs_free_cnt), 64'(D - m_q.size()));
        chk("rs_full", 64'(rs_full), 64'(m_q.size() == D));
        if (m_exv) begin
          chk("ex_v1", 64'(ex_v1), 64'(m_ex.v1));
          chk("ex_v2", 64'(ex_v2), 64'(m_ex.v2));
          chk("ex_rd_tag", 64'(ex_rd_tag), 64'(m_ex.rd));
          chk("ex_op", 64'(ex_op), 64'(m_ex.op));
          chk("ex_type", 64'(ex_type), 64'(m_ex.typ));
          chk("ex_alt", 64'(ex_alt), 64'(m_ex.alt));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic set_iss(input logic [XL-1:0] v1, input logic [XL-1:0] v2, input logic d1,
                         input logic d2, input logic [RW-1:0] t1, input logic [RW-1:0] t2,
                         input logic [RW-1:0] rd);
    issue_valid = 1'b1; issue_op = 3'd0; issue_type = 7'h33; issue_alt = 1'b0;
    issue_v1 = v1; issue_v2 = v2; issue_dep1 = d1; issue_dep2 = d2;
    issue_tag1 = t1; issue_tag2 = t2; issue_rd_tag = rd;
  endtask

  initial begin
    idle();
    set_iss(0, 0, 0, 0, 0, 0, 0);
    issue_valid = 1'b0;
    ex_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("rst ex_valid", 64'(ex_valid), 64'd0);
    chk("rst ex_v1", 64'(ex_v1), 64'd0);
    chk("rst free", 64'(rs_free_cnt), 64'd8);
    chk("rst full", 64'(rs_full), 64'd0);

    // Three independent ADDs dispatch in order, one per cycle.
    idle();
    for (int i = 1; i <= 3; i++) begin
      set_iss(i, 10, 0, 0, 0, 0, RW'(i));
      tick();
      if (i > 1) chk("add order", 64'(ex_v1), 64'(i - 1));
    end
    idle();
    tick();
    chk("add third", 64'(ex_v1), 64'd3);
    chk("add rd", 64'(ex_rd_tag), 64'd3);
    tick();
    chk("add drained", 64'(rs_free_cnt), 64'd8);

    // Fill with waiters on tag 5, overflow issue ignored, then one broadcast releases all.
    for (int i = 0; i < 8; i++) begin
      set_iss(0, 1, 1, 0, 5, 0, RW'(i));
      tick();
    end
    chk("fill full", 64'(rs_full), 64'd1);
    set_iss(0, 1, 0, 0, 0, 0, 15);
    tick();
    chk("overflow ignored", 64'(rs_free_cnt), 64'd0);
    idle();
    cdb_valid = 2'b10; cdb_tag = {4'd5, 4'd0}; cdb_value = {32'hDEAD, 32'h0};
    tick();
    idle();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("release v1", 64'(ex_v1), 64'hDEAD);
      chk("release order", 64'(ex_rd_tag), 64'(k));
    end
    tick();

    // Same-cycle bypass on operand 2.
    set_iss(5, 0, 0, 1, 0, 3, 3);
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_value = {32'h0, 32'd42};
    tick();
    idle();
    tick();
    chk("bypass v2", 64'(ex_v2), 64'd42);
    tick();

    // Back-pressure holds the execute port.
    ex_ready = 1'b0;
    set_iss(100, 0, 0, 0, 0, 0, 1); tick();
    set_iss(200, 0, 0, 0, 0, 0, 2); tick();
    idle();
    tick();
    chk("hold v1", 64'(ex_v1), 64'd100);
    chk("hold free", 64'(rs_free_cnt), 64'd7);
    ex_ready = 1'b1;
    tick();
    chk("release next", 64'(ex_v1), 64'd200);
    tick();

    // Younger ready entry overtakes an older waiter.
    set_iss(0, 0, 1, 0, 7, 0, 1); tick();
    set_iss(9, 0, 0, 0, 0, 0, 2); tick();
    idle();
    tick();
    chk("younger first", 64'(ex_rd_tag), 64'd2);
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_value = {32'h0, 32'd77};
    tick();
    idle();
    tick();
    chk("older next", 64'(ex_rd_tag), 64'd1);
    chk("older value", 64'(ex_v1), 64'd77);
    tick();

    // Flush drops everything, including the execute port.
    ex_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_iss(i, 0, 0, 0, 0, 0, RW'(i)); tick();
    end
    chk("pre-flush free", 64'(rs_free_cnt), 64'd4);
    flush = 1'b1;
    tick();
    chk("flush ex_valid", 64'(ex_valid), 64'd0);
    chk("flush free", 64'(rs_free_cnt), 64'd8);
    idle();

    // rdy low freezes state even with issue and ready asserted.
    ex_ready = 1'b1;
    set_iss(11, 0, 0, 0, 0, 0, 1); tick();
    set_iss(22, 0, 0, 0, 0, 0, 2); tick();
    set_iss(33, 0, 0, 0, 0, 0, 3);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen v1", 64'(ex_v1), 64'd11);
      chk("frozen free", 64'(rs_free_cnt), 64'd7);
    end
    idle();
    tick();
    chk("resume v1", 64'(ex_v1), 64'd22);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 499) != 0);
      flush       = ($urandom_range(0, 99) == 0);
      rdy         = ($urandom_range(0, 9) != 0);
      ex_ready    = ($urandom_range(0, 9) < 7);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_op    = 3'($urandom);
      issue_type  = 7'($urandom);
      issue_alt   = 1'($urandom);
      issue_v1    = $urandom;
      issue_v2    = $urandom;
      issue_dep1  = 1'($urandom);
      issue_dep2  = 1'($urandom);
      issue_tag1  = RW'($urandom_range(0, 7));
      issue_tag2  = RW'($urandom_range(0, 7));
      issue_rd_tag = RW'($urandom);
      for (int c = 0; c < NC; c++) begin
        cdb_valid[c]           = 1'($urandom);
        cdb_tag[c*RW +: RW]    = RW'($urandom_range(0, 7));
        cdb_value[c*XL +: XL]  = $urandom;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
